// File: rtl/uart_dump_pkg.sv
// Shared types and constants for the UART memory-dump master.
// Covers the RIB bus widths, the FSM state encoding and the baud divider.
package uart_dump_pkg;

  localparam int MEM_ADDR_W = 32;  // MemAddrBus
  localparam int MEM_DATA_W = 32;  // MemBus

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_SEND  = 3'd2,
    S_CKSUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. Every bit lasts DIV clocks.
// ready_o is also high in the last stop-bit cycle, so bytes can be sent back-to-back.
module uart_tx_byte #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;   // 0 = start bit, 1..8 = data bits, 9 = stop bit
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign ready_o = !active || (bit_end && bit_cnt == 4'd9);

  // NOTE: non-blocking assignments for every register so all of them update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_o     <= 1'b1;
    end else if (valid_i && ready_o) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= data_i;
      tx_o     <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) begin
            tx_o <= 1'b1;
          end else begin
            tx_o  <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_dump.sv
// RIB master that reads word_cnt_i words from base_addr_i and streams them out on tx_pin,
// least significant byte first, followed by an 8-bit sum-mod-256 checksum byte.
module uart_dump
  import uart_dump_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [MEM_ADDR_W-1:0] base_addr_i,
  input  logic [15:0]           word_cnt_i,
  output logic                  req_o,
  output logic                  we_o,
  output logic [MEM_ADDR_W-1:0] addr_o,
  output logic [MEM_DATA_W-1:0] data_o,
  input  logic [MEM_DATA_W-1:0] data_i,
  input  logic                  ack_i,
  output logic                  tx_pin,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  state_t                state, state_n;
  logic [MEM_ADDR_W-1:0] addr_n;
  logic [15:0]           remain, remain_n;
  logic [7:0]            cksum, cksum_n;
  logic [23:0]           word_hi, word_hi_n;  // byte 0 goes straight from the bus to the TX
  logic [1:0]            byte_idx, byte_idx_n;
  logic                  sent, sent_n;
  logic                  tx_valid, tx_ready;
  logic [7:0]            tx_data;

  assign we_o   = 1'b0;
  assign data_o = '0;

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .valid_i (tx_valid),
    .data_i  (tx_data),
    .ready_o (tx_ready),
    .tx_o    (tx_pin)
  );

  // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    addr_n     = addr_o;
    remain_n   = remain;
    cksum_n    = cksum;
    word_hi_n  = word_hi;
    byte_idx_n = byte_idx;
    sent_n     = sent;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          addr_n   = base_addr_i;
          remain_n = word_cnt_i;
          cksum_n  = 8'h00;
          sent_n   = 1'b0;
          state_n  = (word_cnt_i != 16'd0) ? S_READ : S_CKSUM;
        end
      end
      S_READ: begin
        // The transmitter is always idle here, so byte 0 starts in the ack cycle itself.
        if (ack_i) begin
          word_hi_n  = data_i[31:8];
          tx_valid   = 1'b1;
          tx_data    = data_i[7:0];
          cksum_n    = cksum + data_i[7:0];
          byte_idx_n = 2'd1;
          state_n    = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (byte_idx == 2'd0) begin
            addr_n   = addr_o + 32'd4;
            remain_n = remain - 16'd1;
            state_n  = (remain != 16'd1) ? S_READ : S_CKSUM;
          end else begin
            unique case (byte_idx)
              2'd1:    tx_data = word_hi[7:0];
              2'd2:    tx_data = word_hi[15:8];
              default: tx_data = word_hi[23:16];
            endcase
            tx_valid   = 1'b1;
            cksum_n    = cksum + tx_data;
            byte_idx_n = byte_idx + 2'd1;
          end
        end
      end
      S_CKSUM: begin
        if (!sent) begin
          tx_valid = 1'b1;
          tx_data  = cksum;
          sent_n   = 1'b1;
        end else if (tx_ready) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_o   <= '0;
      remain   <= '0;
      cksum    <= '0;
      word_hi  <= '0;
      byte_idx <= '0;
      sent     <= 1'b0;
      req_o    <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_n;
      addr_o   <= addr_n;
      remain   <= remain_n;
      cksum    <= cksum_n;
      word_hi  <= word_hi_n;
      byte_idx <= byte_idx_n;
      sent     <= sent_n;
      req_o    <= (state_n == S_READ);
      busy_o   <= (state_n != S_IDLE);
      done_o   <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_uart_dump.sv
// Self-checking bench for uart_dump: a RIB memory responder, a cycle-accurate UART monitor
// and a scoreboard of expected bytes and addresses, driven from a table of dump vectors.
module tb_uart_dump;

  localparam int DIV = 4;

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    int          delay;
    logic [31:0] w [3];
    logic [7:0]  cks;
    bit          poke;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] word_cnt_i;
  logic        req_o, we_o, ack_i, tx_pin, busy_o, done_o;
  logic [31:0] addr_o, data_o, data_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] mem_base;
  logic [31:0] mem_words [3];
  int          ack_delay;

  logic [7:0]  exp_bytes [$];
  logic [31:0] exp_addr [$];
  int          rx_starts [$];
  int          rx_ends [$];
  int          ack_cycs [$];

  int   req_cnt, done_cnt, done_cyc;
  logic busy_prev, busy_at_done, busy_before_done;
  bit   rx_active;
  int   rx_cyc;

  vec_t tbl [5];

  uart_dump #(.CLK_FREQ(4), .BAUD(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .word_cnt_i  (word_cnt_i),
    .req_o       (req_o),
    .we_o        (we_o),
    .addr_o      (addr_o),
    .data_o      (data_o),
    .data_i      (data_i),
    .ack_i       (ack_i),
    .tx_pin      (tx_pin),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fetch(input logic [31:0] a);
    logic [31:0] off;
    off = a - mem_base;
    if (off[1:0] == 2'b00 && off < 32'd12) return mem_words[off[3:2]];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic vec_t mk(input logic [31:0] base, input logic [15:0] cnt, input int delay,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [7:0] cks, input bit poke);
    vec_t v;
    v.base  = base;
    v.cnt   = cnt;
    v.delay = delay;
    v.w[0]  = w0;
    v.w[1]  = w1;
    v.w[2]  = w2;
    v.cks   = cks;
    v.poke  = poke;
    return v;
  endfunction

  // RIB memory: acks after ack_delay stall cycles; data_i carries junk outside the ack cycle.
  initial begin
    int wait_cnt;
    logic [32:0] want;
    ack_i    = 1'b0;
    data_i   = 32'hDEAD_BEEF;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !req_o) begin
        ack_i    = 1'b0;
        data_i   = 32'hDEAD_BEEF;
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) req_cnt++;
        if (wait_cnt == ack_delay) begin
          ack_i  = 1'b1;
          data_i = fetch(addr_o);
          ack_cycs.push_back(cyc);
          want = (exp_addr.size() > 0) ? {1'b1, exp_addr.pop_front()} : 33'h0;
          check("rib_addr", {7'd0, 1'b1, addr_o}, {7'd0, want});
          check("rib_read_only", {we_o, data_o}, 33'h0);
          wait_cnt = 0;
        end else begin
          ack_i  = 1'b0;
          data_i = 32'hDEAD_BEEF;
          wait_cnt++;
        end
      end
    end
  end

  // UART monitor: samples one step after each rising edge, checks every bit is DIV cycles wide.
  initial begin
    int   bidx, pos;
    logic rx_bit;
    bit   rx_ok;
    logic [7:0] rx_byte;
    logic [8:0] want;
    rx_active = 1'b0;
    rx_cyc    = 0;
    rx_ok     = 1'b1;
    rx_bit    = 1'b1;
    rx_byte   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        rx_active = 1'b0;
        busy_prev = 1'b0;
        continue;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc         = cyc;
        busy_at_done     = busy_o;
        busy_before_done = busy_prev;
      end
      busy_prev = busy_o;
      if (!rx_active && tx_pin == 1'b0) begin
        rx_active = 1'b1;
        rx_cyc    = 0;
        rx_ok     = 1'b1;
        rx_starts.push_back(cyc);
      end else if (rx_active) begin
        rx_cyc++;
      end
      if (rx_active) begin
        bidx = rx_cyc / DIV;
        pos  = rx_cyc % DIV;
        if (pos == 0) begin
          rx_bit = tx_pin;
          if (bidx == 0 && tx_pin !== 1'b0) rx_ok = 1'b0;
          if (bidx >= 1 && bidx <= 8) rx_byte[bidx-1] = tx_pin;
          if (bidx == 9 && tx_pin !== 1'b1) rx_ok = 1'b0;
        end else if (tx_pin !== rx_bit) begin
          rx_ok = 1'b0;
        end
        if (rx_cyc == 10*DIV - 1) begin
          rx_active = 1'b0;
          rx_ends.push_back(cyc);
          check("frame_shape", {39'd0, rx_ok}, 40'd1);
          want = (exp_bytes.size() > 0) ? {1'b1, exp_bytes.pop_front()} : 9'h000;
          check("tx_byte", {31'd0, 1'b1, rx_byte}, {31'd0, want});
        end
      end
    end
  end

  task automatic clear_logs();
    exp_bytes.delete();
    exp_addr.delete();
    rx_starts.delete();
    rx_ends.delete();
    ack_cycs.delete();
    req_cnt  = 0;
    done_cnt = 0;
    done_cyc = -1;
    busy_at_done     = 1'bx;
    busy_before_done = 1'bx;
  endtask

  task automatic run_dump(input vec_t v);
    int budget, waited, n, cnt;
    logic [31:0] a;
    cnt       = int'(v.cnt);
    mem_base  = v.base;
    mem_words = v.w;
    ack_delay = v.delay;
    clear_logs();
    a = v.base;
    for (int k = 0; k < cnt; k++) begin
      exp_addr.push_back(a);
      a = a + 32'd4;
      for (int b = 0; b < 4; b++) exp_bytes.push_back(8'(v.w[k] >> (8*b)));
    end
    exp_bytes.push_back(v.cks);

    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = v.base;
    word_cnt_i  = v.cnt;
    @(negedge clk);
    start_i     = 1'b0;
    base_addr_i = $urandom;
    word_cnt_i  = 16'($urandom);
    check("req_after_start", {39'd0, req_o}, {39'd0, (cnt != 0)});
    check("busy_after_start", {39'd0, busy_o}, 40'd1);

    if (v.poke) begin
      waited = 0;
      while (rx_starts.size() == 0 && waited < 1000) begin
        @(negedge clk);
        waited++;
      end
      check("poke_in_send", {39'd0, rx_starts.size() != 0}, 40'd1);
      start_i     = 1'b1;
      base_addr_i = 32'h7000_0000;
      word_cnt_i  = 16'd5;
      @(negedge clk);
      start_i = 1'b0;
    end

    budget = (4*cnt + 1) * 10 * DIV + cnt * (v.delay + 4) + 100;
    waited = 0;
    while (done_cnt == 0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check("done_seen", {39'd0, done_cnt != 0}, 40'd1);
    repeat (3*DIV) @(negedge clk);

    check("done_pulses", 40'(done_cnt), 40'd1);
    check("busy_falls_with_done", {38'd0, busy_before_done, busy_at_done}, 40'b10);
    check("idle_after_done", {38'd0, busy_o, tx_pin}, 40'b01);
    check("bytes_outstanding", 40'(exp_bytes.size()), 40'd0);
    check("addrs_outstanding", 40'(exp_addr.size()), 40'd0);
    check("read_requests", 40'(req_cnt), 40'(cnt));
    n = 4*cnt + 1;
    check("frame_count", 40'(rx_ends.size()), 40'(n));
    if (rx_ends.size() == n && rx_starts.size() == n) begin
      check("done_after_cksum", 40'(done_cyc), 40'(rx_ends[n-1] + 2));
      if (ack_cycs.size() == cnt) begin
        for (int k = 0; k < cnt; k++) begin
          check("start_after_ack", 40'(rx_starts[4*k]), 40'(ack_cycs[k] + 1));
          for (int b = 1; b < 4; b++)
            check("bytes_back_to_back", 40'(rx_starts[4*k+b]), 40'(rx_ends[4*k+b-1] + 1));
          if (k > 0)
            check("word_gap", 40'(rx_starts[4*k] - rx_ends[4*k-1] - 1), 40'(1 + v.delay));
        end
      end
    end
  endtask

  initial begin
    int waited;
    start_i     = 1'b0;
    base_addr_i = '0;
    word_cnt_i  = '0;
    mem_base    = '0;
    mem_words   = '{32'h0, 32'h0, 32'h0};
    ack_delay   = 0;
    clear_logs();

    tbl[0] = mk(32'h1000_0000, 16'd1, 0, 32'h4433_2211, 32'h0, 32'h0, 8'hAA, 1'b0);
    tbl[1] = mk(32'h2000_0000, 16'd0, 0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0);
    tbl[2] = mk(32'hFFFF_FFF8, 16'd3, 5, 32'h0102_0304, 32'hA0B0_C0D0, 32'h0F0E_0D0C, 8'h20, 1'b0);
    tbl[3] = mk(32'h0000_0100, 16'd2, 1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 8'hFE, 1'b0);
    tbl[4] = mk(32'h0000_0200, 16'd2, 2, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 8'h38, 1'b1);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {5'd0, tx_pin, req_o, busy_o, done_o, addr_o}, {5'd0, 4'b1000, 32'h0});
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", {36'd0, tx_pin, req_o, busy_o, done_o}, {36'd0, 4'b1000});

    for (int i = 0; i < 5; i++) run_dump(tbl[i]);

    // Reset during bit 3 of the second byte, then a fresh full dump.
    clear_logs();
    mem_base  = tbl[0].base;
    mem_words = tbl[0].w;
    ack_delay = 0;
    exp_addr.push_back(tbl[0].base);
    exp_bytes.push_back(8'h11);
    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = tbl[0].base;
    word_cnt_i  = tbl[0].cnt;
    @(negedge clk);
    start_i = 1'b0;
    waited  = 0;
    while (!(rx_ends.size() == 1 && rx_active && rx_cyc == 3*DIV + 1) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("reached_byte2_bit3", {39'd0, waited < 500}, 40'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_frame", {5'd0, tx_pin, req_o, busy_o, done_o, addr_o}, {5'd0, 4'b1000, 32'h0});
    repeat (2) @(negedge clk);
    check("rst_held", {37'd0, tx_pin, req_o, busy_o}, {37'd0, 3'b100});
    rst = 1'b0;
    @(negedge clk);
    run_dump(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_dump.md
# uart_dump

RIB bus master that reads a block of 32-bit words from memory and streams them out over a UART TX pin, followed by an 8-bit checksum. It is the read-back counterpart of the serial download path, which writes memory from UART. It occupies a free RIB master port at the SoC top and drives its own TX pin.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate. `DIV = CLK_FREQ/BAUD` is an integer, and `DIV ≥ 2`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  one-cycle start pulse; sampled only in IDLE.
- `base_addr_i`  in  32  first word address (word-aligned).
- `word_cnt_i`  in  16  number of words to dump.
- `req_o`  out  1  RIB request.
- `we_o`  out  1  RIB write enable; constant 0.
- `addr_o`  out  32  RIB address.
- `data_o`  out  32  RIB write data; constant 0.
- `data_i`  in  32  RIB read data.
- `ack_i`  in  1  RIB acknowledge/grant.
- `tx_pin`  out  1  UART TX, idle high.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when the dump completes.

## Operation
- **States:** IDLE, READ, SEND, CKSUM, DONE.
- **IDLE:**
  - On `start_i`, latch `base_addr_i` into the address register and `word_cnt_i` into the remaining counter, and clear the checksum.
  - Next state is READ if the count is nonzero, else CKSUM.
- **READ:**
  - Hold `req_o`=1 with `addr_o`=address until `ack_i`=1.
  - In the ack cycle, capture `data_i` into the word buffer, drop `req_o` the next cycle, and go to SEND.
- **SEND:**
  - Transmit the buffer as 4 bytes, little-endian (bits [7:0] first).
  - Each byte is 8N1: start bit 0, data LSB first, stop bit 1.
  - Add each byte to the checksum, an 8-bit sum modulo 256.
  - After the 4th stop bit: address += 4 (wraps mod 2^32) and remaining -= 1. Go to READ if remaining ≠ 0, else CKSUM.
- **CKSUM:** transmit the checksum byte as one 8N1 frame, then go to DONE.
- **DONE:** assert `done_o` for one cycle, then go to IDLE.
- **Boundaries:**
  - `start_i` outside IDLE is ignored.
  - If `ack_i` never arrives, stay in READ indefinitely with `req_o` held.
  - `word_cnt_i`=0 emits only the checksum byte 0x00.
  - Maximum count 65535 has no overflow.
- **Reset (any time, including mid-frame):**
  - Return to IDLE immediately.
  - `tx_pin`=1, `req_o`=0, `addr_o`=0, `busy_o`=0, `done_o`=0, checksum=0.
  - A partially sent frame is abandoned with the line high.

## Timing
- Every bit lasts exactly `DIV` clocks, so a frame is `10*DIV` clocks.
- A start pulse at cycle T puts `req_o` high at T+1.
- With `ack_i` in the same cycle as `req_o`, the start bit begins 1 cycle after the ack cycle.
- Bytes within a word are back-to-back, with no idle gap between a stop bit and the next start bit.
- Between words there is a line-high gap of exactly 1 + (ack wait) cycles for the READ.
- `done_o` pulses 1 cycle after the checksum stop bit ends. `busy_o` falls in the same cycle `done_o` is asserted.
- All outputs are registered.

## Structure
- Shared package/defines:
  - state encoding (3 bits).
  - `DIV` derivation.
  - RIB widths, reusing the existing MemAddrBus/MemBus defines.
- Sub-module `uart_tx_byte`:
  - Ports: `clk`, `rst`, `valid_i`, `data_i[7:0]`, `ready_o`, `tx_o`.
  - Contains the baud counter (`$clog2(DIV)` bits) and a 4-bit bit counter.
  - Accepts a byte when `valid_i && ready_o`.
- `uart_dump` owns the FSM, address/count/byte-index registers, the checksum, and the RIB handshake.

## Test plan
- **Single word:** `DIV`=4, base 0x1000_0000, cnt=1, memory 0x44332211, ack same cycle.
  - TX bytes: 0x11, 0x22, 0x33, 0x44, checksum 0xAA.
  - Each bit is 4 cycles.
  - `done_o` pulses once; `busy_o` falls with it.
- **Zero count:** cnt=0.
  - No `req_o` ever.
  - A single frame 0x00 is sent, then `done_o`.
- **Ack stall and wrap:** cnt=3, base 0xFFFF_FFF8, `ack_i` delayed 5 cycles on each read.
  - `addr_o` sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - `req_o` is held through each stall.
  - The ack-cycle data is captured.
- **Checksum wrap:** cnt=2 with words 0xFFFFFFFF and 0x00000002 → checksum 0xFE.
- **Reset mid-frame:** assert `rst` during bit 3 of byte 2.
  - `tx_pin`=1, `req_o`=0, `busy_o`=0 immediately.
  - A fresh start afterward produces a correct full dump.
- **Start while busy:** a second `start_i` during SEND is ignored; the original count and addresses are preserved.
